// File: rtl/align_shift_seq_pkg.sv
// Shared types and sizing helpers for the exponent-alignment shift sequencer.
package align_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } align_state_t;

  // Stage counter width: enough to index SHW shift stages, at least one bit.
  function automatic int cnt_w(input int shw);
    return (shw <= 2) ? 1 : $clog2(shw);
  endfunction

endpackage

// File: rtl/align_shift_seq_if.sv
// Request/result handshake bundle for align_shift_seq.
interface align_shift_seq_if #(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sig;
  logic [SHW-1:0]   in_shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sig;
  logic             out_sticky;
  logic             out_zero;
  logic             busy;

  modport master (
    output in_valid, in_sig, in_shamt, out_ready,
    input  in_ready, out_valid, out_sig, out_sticky, out_zero, busy
  );

  modport slave (
    input  in_valid, in_sig, in_shamt, out_ready,
    output in_ready, out_valid, out_sig, out_sticky, out_zero, busy
  );
endinterface

// File: rtl/align_shift_seq_hdec.sv
// Half-decoder: thermometer mask with bit i set iff i < shamt.
module HDec #(
  parameter int N = 5
) (
  input  logic [N-1:0]    shamt,
  output logic [2**N-1:0] mask
);
  always_comb begin
    mask = '0;
    for (int i = 0; i < 2**N; i++) begin
      mask[i] = (N'(i) < shamt);
    end
  end
endmodule

// File: rtl/align_shift_seq.sv
// Sequential log right shifter (one stage per clock, LSB first) with sticky output.
// Build option: define ALIGN_SEQ_STICKY_EN to compute the sticky bit; otherwise out_sticky is 0.
module align_shift_seq
  import align_seq_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int SHW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  align_shift_seq_if.slave  bus
);
  localparam int KW = cnt_w(SHW);

  align_state_t     state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d, shifted;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [KW-1:0]    k_q, k_d;
  logic             sticky_q, sticky_d, sticky_in;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

`ifdef ALIGN_SEQ_STICKY_EN
  logic [2**SHW-1:0] mask;
  logic [2**SHW-1:0] sig_pad;

  HDec #(.N(SHW)) u_hdec (
    .shamt (bus.in_shamt),
    .mask  (mask)
  );

  assign sig_pad   = (2**SHW)'(bus.in_sig);
  assign sticky_in = |(sig_pad & mask);
`else
  assign sticky_in = 1'b0;
`endif

  // Single shared stage; shift distances at or beyond WIDTH flush to zero.
  always_comb begin
    shifted = sig_q;
    if (sh_q[k_q]) shifted = sig_q >> (32'd1 << k_q);
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    sh_d     = sh_q;
    k_d      = k_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sig_d    = bus.in_sig;
          sh_d     = bus.in_shamt;
          sticky_d = sticky_in;
          k_d      = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sig_d = shifted;
        if (k_q == KW'(SHW - 1)) begin
          zero_d  = (shifted == '0);
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sig_q       <= '0;
      sh_q        <= '0;
      k_q         <= '0;
      sticky_q    <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      sh_q        <= sh_d;
      k_q         <= k_d;
      sticky_q    <= sticky_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sig    = sig_q;
  assign bus.out_sticky = sticky_q;
  assign bus.out_zero   = zero_q;
  assign bus.busy       = busy_q;
endmodule
